// File: rtl/exmem_stage.sv
// rtl/exmem_stage.sv - LEGv8 execute stage and EX/MEM pipeline register
// Resolves branches here and squashes the wrong-path instructions behind a taken one.
module exmem_stage #(
  parameter int WIDTH        = 64,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             stall,
  input  logic             flush,
  input  logic             IDEX_valid,
  input  logic [1:0]       IDEX_aluop,
  input  logic             IDEX_alusrc,
  input  logic             IDEX_isZeroBranch,
  input  logic             IDEX_isUnconBranch,
  input  logic             IDEX_memRead,
  input  logic             IDEX_memwrite,
  input  logic             IDEX_regwrite,
  input  logic             IDEX_mem2reg,
  input  logic [WIDTH-1:0] IDEX_PC,
  input  logic [WIDTH-1:0] IDEX_reg_data_1,
  input  logic [WIDTH-1:0] IDEX_reg_data_2,
  input  logic [WIDTH-1:0] IDEX_imm,
  input  logic [10:0]      IDEX_opcode,
  input  logic [4:0]       IDEX_write_reg,
  output logic             EXMEM_valid,
  output logic             EXMEM_memRead,
  output logic             EXMEM_memwrite,
  output logic             EXMEM_regwrite,
  output logic             EXMEM_mem2reg,
  output logic [WIDTH-1:0] EXMEM_alu_result,
  output logic             EXMEM_alu_zero,
  output logic [WIDTH-1:0] EXMEM_store_data,
  output logic [WIDTH-1:0] EXMEM_branch_target,
  output logic [4:0]       EXMEM_write_reg,
  output logic             EXMEM_pc_src,
  output logic             EXMEM_illegal,
  output logic             squash_active
);

  localparam int CW = $clog2(SQUASH_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(SQUASH_DEPTH);

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  typedef struct packed {
    logic             valid;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem2reg;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic [WIDTH-1:0] store_data;
    logic [WIDTH-1:0] branch_target;
    logic [4:0]       write_reg;
    logic             pc_src;
    logic             illegal;
  } exmem_t;

  exmem_t          exmem_q, exmem_d, ex_c;
  logic [CW-1:0]   squash_cnt_q, squash_cnt_d;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] alu_res;
  logic            alu_illegal;

  always_comb begin
    operand_b   = IDEX_alusrc ? IDEX_imm : IDEX_reg_data_2;
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (IDEX_aluop)
      2'b00: alu_res = IDEX_reg_data_1 + operand_b;
      2'b01: alu_res = operand_b;
      2'b10: begin
        case (IDEX_opcode)
          OPC_ADD: alu_res = IDEX_reg_data_1 + operand_b;
          OPC_SUB: alu_res = IDEX_reg_data_1 - operand_b;
          OPC_AND: alu_res = IDEX_reg_data_1 & operand_b;
          OPC_ORR: alu_res = IDEX_reg_data_1 | operand_b;
          default: alu_illegal = 1'b1;
        endcase
      end
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    ex_c               = '0;
    ex_c.valid         = 1'b1;
    ex_c.mem_read      = IDEX_memRead;
    ex_c.mem_write     = IDEX_memwrite;
    ex_c.reg_write     = IDEX_regwrite;
    ex_c.mem2reg       = IDEX_mem2reg;
    ex_c.alu_result    = alu_res;
    ex_c.alu_zero      = (alu_res == '0);
    ex_c.store_data    = IDEX_reg_data_2;
    ex_c.branch_target = IDEX_PC + (IDEX_imm << 2);
    ex_c.write_reg     = IDEX_write_reg;
    ex_c.pc_src        = IDEX_isUnconBranch | (IDEX_isZeroBranch & ex_c.alu_zero);
    ex_c.illegal       = alu_illegal;
    if (!IDEX_valid) ex_c = '0;
  end

  // Squash outranks stall so wrong-path slots are always drained, never held.
  always_comb begin
    exmem_d      = exmem_q;
    squash_cnt_d = squash_cnt_q;
    if (flush || squash_cnt_q != '0) begin
      exmem_d = '0;
      if (squash_cnt_q != '0) squash_cnt_d = squash_cnt_q - CW'(1);
    end else if (!stall) begin
      exmem_d      = ex_c;
      squash_cnt_d = ex_c.pc_src ? DEPTH_C : '0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      exmem_q      <= '0;
      squash_cnt_q <= '0;
    end else begin
      exmem_q      <= exmem_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign EXMEM_valid         = exmem_q.valid;
  assign EXMEM_memRead       = exmem_q.mem_read;
  assign EXMEM_memwrite      = exmem_q.mem_write;
  assign EXMEM_regwrite      = exmem_q.reg_write;
  assign EXMEM_mem2reg       = exmem_q.mem2reg;
  assign EXMEM_alu_result    = exmem_q.alu_result;
  assign EXMEM_alu_zero      = exmem_q.alu_zero;
  assign EXMEM_store_data    = exmem_q.store_data;
  assign EXMEM_branch_target = exmem_q.branch_target;
  assign EXMEM_write_reg     = exmem_q.write_reg;
  assign EXMEM_pc_src        = exmem_q.pc_src;
  assign EXMEM_illegal       = exmem_q.illegal;
  assign squash_active       = (squash_cnt_q != '0);

endmodule

// File: tb/tb_exmem_stage.sv
// tb/tb_exmem_stage.sv - scoreboard bench for exmem_stage
module tb_exmem_stage;

  logic        CLOCK = 1'b0;
  logic        RESET, stall, flush;
  logic        IDEX_valid, IDEX_alusrc, IDEX_isZeroBranch, IDEX_isUnconBranch;
  logic [1:0]  IDEX_aluop;
  logic        IDEX_memRead, IDEX_memwrite, IDEX_regwrite, IDEX_mem2reg;
  logic [63:0] IDEX_PC, IDEX_reg_data_1, IDEX_reg_data_2, IDEX_imm;
  logic [10:0] IDEX_opcode;
  logic [4:0]  IDEX_write_reg;
  logic        EXMEM_valid, EXMEM_memRead, EXMEM_memwrite, EXMEM_regwrite, EXMEM_mem2reg;
  logic [63:0] EXMEM_alu_result, EXMEM_store_data, EXMEM_branch_target;
  logic        EXMEM_alu_zero, EXMEM_pc_src, EXMEM_illegal, squash_active;
  logic [4:0]  EXMEM_write_reg;

  localparam logic [10:0] ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000;

  typedef struct packed {
    logic        valid, mr, mw, rw, m2r;
    logic [63:0] res;
    logic        zero;
    logic [63:0] sd, tgt;
    logic [4:0]  wr;
    logic        pcs, ill, sq;
  } exp_t;

  exp_t exp_q[$];
  exp_t model = '0;
  int   model_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exmem_stage #(.WIDTH(64), .SQUASH_DEPTH(2)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .stall(stall), .flush(flush),
    .IDEX_valid(IDEX_valid), .IDEX_aluop(IDEX_aluop), .IDEX_alusrc(IDEX_alusrc),
    .IDEX_isZeroBranch(IDEX_isZeroBranch), .IDEX_isUnconBranch(IDEX_isUnconBranch),
    .IDEX_memRead(IDEX_memRead), .IDEX_memwrite(IDEX_memwrite),
    .IDEX_regwrite(IDEX_regwrite), .IDEX_mem2reg(IDEX_mem2reg),
    .IDEX_PC(IDEX_PC), .IDEX_reg_data_1(IDEX_reg_data_1), .IDEX_reg_data_2(IDEX_reg_data_2),
    .IDEX_imm(IDEX_imm), .IDEX_opcode(IDEX_opcode), .IDEX_write_reg(IDEX_write_reg),
    .EXMEM_valid(EXMEM_valid), .EXMEM_memRead(EXMEM_memRead), .EXMEM_memwrite(EXMEM_memwrite),
    .EXMEM_regwrite(EXMEM_regwrite), .EXMEM_mem2reg(EXMEM_mem2reg),
    .EXMEM_alu_result(EXMEM_alu_result), .EXMEM_alu_zero(EXMEM_alu_zero),
    .EXMEM_store_data(EXMEM_store_data), .EXMEM_branch_target(EXMEM_branch_target),
    .EXMEM_write_reg(EXMEM_write_reg), .EXMEM_pc_src(EXMEM_pc_src),
    .EXMEM_illegal(EXMEM_illegal), .squash_active(squash_active)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [1:0] op, input bit src, input bit zb, input bit ub,
                        input bit mr, input bit mw, input bit rw, input bit m2r,
                        input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic [10:0] opc, input logic [4:0] wr);
    IDEX_valid = v; IDEX_aluop = op; IDEX_alusrc = src;
    IDEX_isZeroBranch = zb; IDEX_isUnconBranch = ub;
    IDEX_memRead = mr; IDEX_memwrite = mw; IDEX_regwrite = rw; IDEX_mem2reg = m2r;
    IDEX_PC = pc; IDEX_reg_data_1 = a; IDEX_reg_data_2 = b; IDEX_imm = imm;
    IDEX_opcode = opc; IDEX_write_reg = wr;
  endtask

  function automatic exp_t predict();
    exp_t e = '0;
    logic [63:0] bop = IDEX_alusrc ? IDEX_imm : IDEX_reg_data_2;
    if (!IDEX_valid) return e;
    e.valid = 1; e.mr = IDEX_memRead; e.mw = IDEX_memwrite;
    e.rw = IDEX_regwrite; e.m2r = IDEX_mem2reg;
    if (IDEX_aluop == 2'b00) e.res = IDEX_reg_data_1 + bop;
    else if (IDEX_aluop == 2'b01) e.res = bop;
    else if (IDEX_aluop == 2'b10 && IDEX_opcode == ADD) e.res = IDEX_reg_data_1 + bop;
    else if (IDEX_aluop == 2'b10 && IDEX_opcode == SUB) e.res = IDEX_reg_data_1 - bop;
    else if (IDEX_aluop == 2'b10 && IDEX_opcode == AND) e.res = IDEX_reg_data_1 & bop;
    else if (IDEX_aluop == 2'b10 && IDEX_opcode == ORR) e.res = IDEX_reg_data_1 | bop;
    else e.ill = 1;
    e.zero = (e.res == 64'd0);
    e.sd   = IDEX_reg_data_2;
    e.tgt  = IDEX_PC + {IDEX_imm[61:0], 2'b00};
    e.wr   = IDEX_write_reg;
    e.pcs  = IDEX_isUnconBranch || (IDEX_isZeroBranch && e.zero);
    return e;
  endfunction

  task automatic step(input string pfx, input bit rst, input bit stl, input bit fl);
    exp_t e;
    @(negedge CLOCK);
    RESET = rst; stall = stl; flush = fl;
    if (rst) begin
      model = '0; model_cnt = 0;
    end else if (fl || model_cnt > 0) begin
      model = '0;
      if (model_cnt > 0) model_cnt--;
    end else if (!stl) begin
      model = predict();
      model_cnt = model.pcs ? 2 : 0;
    end
    model.sq = (model_cnt != 0);
    exp_q.push_back(model);
    @(posedge CLOCK);
    #1;
    e = exp_q.pop_front();
    expect_eq({pfx, ".valid"}, 64'(EXMEM_valid), 64'(e.valid));
    expect_eq({pfx, ".memRead"}, 64'(EXMEM_memRead), 64'(e.mr));
    expect_eq({pfx, ".memwrite"}, 64'(EXMEM_memwrite), 64'(e.mw));
    expect_eq({pfx, ".regwrite"}, 64'(EXMEM_regwrite), 64'(e.rw));
    expect_eq({pfx, ".mem2reg"}, 64'(EXMEM_mem2reg), 64'(e.m2r));
    expect_eq({pfx, ".alu_result"}, EXMEM_alu_result, e.res);
    expect_eq({pfx, ".alu_zero"}, 64'(EXMEM_alu_zero), 64'(e.zero));
    expect_eq({pfx, ".store_data"}, EXMEM_store_data, e.sd);
    expect_eq({pfx, ".branch_target"}, EXMEM_branch_target, e.tgt);
    expect_eq({pfx, ".write_reg"}, 64'(EXMEM_write_reg), 64'(e.wr));
    expect_eq({pfx, ".pc_src"}, 64'(EXMEM_pc_src), 64'(e.pcs));
    expect_eq({pfx, ".illegal"}, 64'(EXMEM_illegal), 64'(e.ill));
    expect_eq({pfx, ".squash_active"}, 64'(squash_active), 64'(e.sq));
  endtask

  initial begin
    RESET = 1'b1; stall = 1'b1; flush = 1'b1;
    set_in(1, 2'b10, 1, 1, 1, 1, 1, 1, 1, 64'hdead, 64'hbeef, 64'h1234, 64'h55, ADD, 5'd31);
    step("reset", 1, 1, 1);
    expect_eq("reset_valid_direct", 64'(EXMEM_valid), 64'd0);

    set_in(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd3, 64'd2, 64'd0, ADD, 5'd5);
    step("add", 0, 0, 0);
    expect_eq("add_result_direct", EXMEM_alu_result, 64'd5);
    set_in(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd3, 64'd3, 64'd0, SUB, 5'd6);
    step("sub", 0, 0, 0);
    expect_eq("sub_zero_direct", 64'(EXMEM_alu_zero), 64'd1);
    set_in(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd2, 64'd3, 64'd0, ORR, 5'd7);
    step("orr", 0, 0, 0);
    set_in(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd2, 64'd3, 64'd0, AND, 5'd8);
    step("and", 0, 0, 0);
    set_in(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd1, 64'd2, 64'd0, SUB, 5'd9);
    step("sub_wrap", 0, 0, 0);

    set_in(1, 2'b00, 1, 0, 0, 1, 0, 1, 1, 64'd0, 64'd10, 64'd99, 64'd1, 11'd0, 5'd2);
    step("ldur", 0, 0, 0);
    expect_eq("ldur_result_direct", EXMEM_alu_result, 64'd11);
    set_in(1, 2'b00, 1, 0, 0, 0, 1, 0, 0, 64'd0, 64'd10, 64'd4, 64'd2, 11'd0, 5'd0);
    step("stur", 0, 0, 0);
    expect_eq("stur_data_direct", EXMEM_store_data, 64'd4);

    set_in(1, 2'b01, 0, 1, 0, 0, 0, 0, 0, 64'd16, 64'd0, 64'd0, 64'd2, 11'd0, 5'd0);
    step("cbz_taken", 0, 0, 0);
    expect_eq("cbz_target_direct", EXMEM_branch_target, 64'd24);
    set_in(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd1, 64'd1, 64'd0, ADD, 5'd3);
    step("squash1", 0, 0, 0);
    step("squash2", 0, 0, 0);
    step("post_squash", 0, 0, 0);
    set_in(1, 2'b01, 0, 1, 0, 0, 0, 0, 0, 64'd16, 64'd0, 64'd1, 64'd2, 11'd0, 5'd0);
    step("cbz_not_taken", 0, 0, 0);
    step("cbz_nt_next", 0, 0, 0);

    set_in(1, 2'b01, 0, 0, 1, 0, 0, 0, 0, 64'd40, 64'd0, 64'd7, 64'd3, 11'd0, 5'd0);
    step("b_taken", 0, 0, 0);
    expect_eq("b_target_direct", EXMEM_branch_target, 64'd52);
    set_in(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd4, 64'd4, 64'd0, ADD, 5'd4);
    step("b_squash_stall1", 0, 1, 0);
    step("b_squash_stall2", 0, 1, 0);
    step("b_after_stall", 0, 1, 0);

    set_in(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd3, 64'd2, 64'd0, ADD, 5'd5);
    step("hold_add", 0, 0, 0);
    set_in(1, 2'b10, 0, 0, 0, 1, 1, 0, 1, 64'd8, 64'd9, 64'd9, 64'd1, SUB, 5'd11);
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i), 0, 1, 0);
    expect_eq("stall_hold_direct", EXMEM_alu_result, 64'd5);
    step("flush_stall", 0, 1, 1);

    set_in(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd3, 64'd2, 64'd0, 11'd0, 5'd1);
    step("illegal_opc", 0, 0, 0);
    expect_eq("illegal_direct", 64'(EXMEM_illegal), 64'd1);
    set_in(1, 2'b11, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd3, 64'd2, 64'd0, ADD, 5'd1);
    step("illegal_aluop", 0, 0, 0);
    set_in(0, 2'b10, 0, 0, 1, 1, 1, 1, 1, 64'd4, 64'd3, 64'd2, 64'd0, ADD, 5'd1);
    step("invalid_in", 0, 0, 0);

    set_in(1, 2'b01, 0, 0, 1, 0, 0, 0, 0, 64'd100, 64'd0, 64'd0, 64'd1, 11'd0, 5'd0);
    step("b_for_flush", 0, 0, 0);
    step("flush_in_squash", 0, 0, 1);
    step("squash_tail", 0, 0, 0);
    step("b_for_reset", 0, 0, 0);
    step("reset_mid_squash", 1, 0, 0);
    set_in(1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 64'd0, 64'd3, 64'd2, 64'd0, ADD, 5'd5);
    step("after_reset", 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      set_in($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             {$urandom, $urandom}, {$urandom, $urandom}, 64'($urandom_range(0, 3)),
             {$urandom, $urandom}, ($urandom_range(0, 1) == 1) ? ADD : SUB, 5'($urandom));
      step($sformatf("rand%0d", i), 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exmem_stage.md
Name: exmem_stage

Overview:
Execute stage plus EX/MEM pipeline register of the pipelined LEGv8 core; consumes ID/EX outputs (control bits, PC, register data, immediate, opcode, destination register). Performs ALU control decode, ALU operation and branch-target computation, and latches results into EX/MEM on CLOCK. Owns branch resolution (pc_src) and wrong-path squashing of the two instructions behind a taken branch. Supports stall and flush from hazard logic.

Parameters:
WIDTH, 64, datapath width
SQUASH_DEPTH, 2, bubbles inserted after a latched taken branch

Ports:
CLOCK  in  1  rising-edge clock
RESET  in  1  synchronous, active-high reset
stall  in  1  hold all EX/MEM outputs
flush  in  1  load bubble this edge
IDEX_valid  in  1  ID/EX holds a real instruction
IDEX_aluop  in  2  00 add, 01 pass-B, 10 R-type decode
IDEX_alusrc  in  1  B operand = imm (1) or regdata2 (0)
IDEX_isZeroBranch  in  1  CBZ
IDEX_isUnconBranch  in  1  B
IDEX_memRead, IDEX_memwrite, IDEX_regwrite, IDEX_mem2reg  in  1 each  M/WB controls
IDEX_PC  in  WIDTH  instruction byte address
IDEX_reg_data_1  in  WIDTH  operand A
IDEX_reg_data_2  in  WIDTH  operand B / store data / CBZ test value
IDEX_imm  in  WIDTH  sign-extended immediate
IDEX_opcode  in  11  instruction[31:21]
IDEX_write_reg  in  5  destination register
EXMEM_valid  out  1  registered valid
EXMEM_memRead, EXMEM_memwrite, EXMEM_regwrite, EXMEM_mem2reg  out  1 each
EXMEM_alu_result  out  WIDTH  ALU result / memory address
EXMEM_alu_zero  out  1  alu_result == 0
EXMEM_store_data  out  WIDTH  registered IDEX_reg_data_2
EXMEM_branch_target  out  WIDTH  IDEX_PC + (IDEX_imm << 2)
EXMEM_write_reg  out  5
EXMEM_pc_src  out  1  taken branch latched; redirect PC to EXMEM_branch_target
EXMEM_illegal  out  1  aluop 10 with undecoded opcode
squash_active  out  1  squash counter nonzero

Behaviour:
- Reset (RESET=1 at edge): all outputs 0, squash counter 0. Dominates stall/flush.
- Edge priority: RESET > flush > squash (counter>0) > stall > capture.
- Capture: combinational EX computed from IDEX_* and registered at edge; latency 1 cycle.
- B operand = alusrc ? IDEX_imm : IDEX_reg_data_2.
- ALU: aluop 00 -> A+B; 01 -> B; 10 by opcode: 10001011000 ADD A+B, 11001011000 SUB A-B, 10001010000 AND, 10101010000 ORR; other opcode -> result 0, illegal=1; aluop 11 -> result 0, illegal=1. Arithmetic modulo 2^WIDTH, no flags beyond zero.
- Branch target: IDEX_PC + (IDEX_imm << 2), modulo 2^WIDTH, computed regardless of branch type.
- pc_src = valid & (isUnconBranch | (isZeroBranch & alu_zero)); registered with the rest.
- Bubble: valid, all M/WB controls, pc_src, illegal = 0; data fields = 0.
- Invalid input (IDEX_valid=0) captured as bubble.
- Squash: on the edge that latches pc_src=1, counter <= SQUASH_DEPTH. On each subsequent non-reset edge with counter>0: load bubble, decrement — even if stall=1 or flush=1 (wrong-path work never held). squash_active = (counter != 0).
- Taken branch cannot be latched while counter>0 (squashed inputs are bubbles).
- Stall (no flush, counter 0): all outputs and counter hold.
- Flush with counter 0: bubble loaded, counter stays 0.
- RESET mid-squash: counter cleared, outputs 0.

Test Plan:
- Reset: drive garbage, RESET=1 one edge -> all outputs 0, squash_active=0; release -> next edge captures normally.
- ADD A=3, B=2, aluop 10, opcode 10001011000, write_reg 5 -> next cycle alu_result=5, regwrite=1, write_reg=5, zero=0; SUB A=3,B=3 -> result 0, zero=1; ORR 2|3 -> 3; AND 2&3 -> 2.
- LDUR A=10, imm=1, alusrc=1, aluop 00 -> alu_result=11, memRead=1, mem2reg=1; STUR store data 4 -> store_data=4, memwrite=1.
- CBZ PC=16, imm=2, B=0 -> pc_src=1, branch_target=24; following two edges give valid=0 with squash_active 1 then 0 and no pc_src; CBZ with B=1 -> pc_src=0, no squash.
- B PC=40, imm=3 -> pc_src=1, target=52; assert stall during squash -> bubbles still inserted, counter still decrements.
- Stall 3 cycles holding an ADD result 5 -> outputs unchanged; flush+stall same edge -> bubble; opcode 0 with aluop 10 -> illegal=1, result 0.
